// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way channel multiplexer:
// output-register state encoding and the default channel data width.
package mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search: returns the first requesting channel found
// starting at ptr and wrapping modulo N.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel valid/ready multiplexer feeding a one-entry output register.
// Define MUX_N_REG_RR_EN to add the rr_mode port and round-robin arbitration.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = 4,
  localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_N_REG_RR_EN
  input  logic                 rr_mode,
`endif
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

  mux_state_t       st;
  logic             slot_free;
  logic             sel_ok;
  logic             sel_mode;
  logic             grant_ok;
  logic             xfer;
  logic [SEL_W-1:0] grant;
  logic [N-1:0]     grant_oh;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (st == ST_FULL);
  assign slot_free = (st == ST_EMPTY) | out_ready;
  assign sel_ok    = ({1'b0, sel} < N_LIM);

`ifdef MUX_N_REG_RR_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign sel_mode = !rr_mode;
  assign grant    = rr_mode ? rr_grant : sel;
  assign grant_ok = rr_mode ? rr_valid : sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end
`else
  assign sel_mode = 1'b1;
  assign grant    = sel;
  assign grant_ok = sel_ok;
`endif

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_oh[i] = 1'b1;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gates ready so nothing is accepted while reset is held.
  assign in_ready = (rst_n & slot_free & grant_ok) ? grant_oh : '0;
  assign xfer     = |(in_valid & in_ready);

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_EMPTY;
      out_data <= '0;
      out_ch   <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (xfer) begin
        st       <= ST_FULL;
        out_data <= grant_data;
        out_ch   <= grant;
      end else if (out_ready) begin
        st       <= ST_EMPTY;
      end
      if (sel_mode && !sel_ok) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: default N=4 instance plus an N=3 instance
// for out-of-range select handling.
module tb_mux_n_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rr_mode;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        sel_err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(16), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_N_REG_RR_EN
    .rr_mode   (rr_mode),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_n_reg #(.WIDTH(16), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_N_REG_RR_EN
    .rr_mode   (1'b0),
`endif
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .sel_err   (sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] val);
    in_data[ch*16 +: 16] = val;
  endtask

  initial begin
    rst_n     = 1'b0;
    rr_mode   = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    out_ready = 1'b1;
    in_data3  = '0;
    in_valid3 = '0;
    sel3      = '0;

    // Reset state, with a valid request present that must not be accepted
    in_valid = 4'b0001;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_ch",    out_ch, 0);
    check("rst_sel_err",   sel_err, 0);
    check("rst_in_ready",  in_ready, 0);
    in_valid = '0;
    rst_n    = 1'b1;

    // Single transfer on channel 2
    sel      = 2'd2;
    in_valid = 4'b0100;
    set_ch(2, 16'hA5A5);
    #1;
    check("sel2_in_ready", in_ready, 4'b0100);
    step();
    in_valid = '0;
    check("sel2_out_valid", out_valid, 1);
    check("sel2_out_data",  out_data, 16'hA5A5);
    check("sel2_out_ch",    out_ch, 2);
    step();
    check("drain_out_valid", out_valid, 0);

    // Stall: hold 16'h1111 from ch0 while ch1 waits with 16'h1234
    sel       = 2'd0;
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_ch(0, 16'h1111);
    step();
    sel      = 2'd1;
    in_valid = 4'b0010;
    set_ch(1, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready",  in_ready, 0);
      check("stall_out_data",  out_data, 16'h1111);
      check("stall_out_ch",    out_ch, 0);
      check("stall_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 4'b0010);
    step();
    in_valid = '0;
    check("unstall_out_data", out_data, 16'h1234);
    check("unstall_out_ch",   out_ch, 1);
    step();
    check("unstall_drain", out_valid, 0);

    // Back-to-back streaming on ch0
    sel      = 2'd0;
    in_valid = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      set_ch(0, 16'(k));
      step();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data",  out_data, k);
    end
    in_valid = '0;
    step();
    check("stream_drain", out_valid, 0);

    // Out-of-range select on the N=3 instance
    check("n3_sel_err_init", sel_err3, 0);
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    set_ch(0, 16'h0);
    in_data3  = {16'h3333, 16'h2222, 16'h1111};
    #1;
    check("n3_bad_in_ready", in_ready3, 0);
    step();
    check("n3_sel_err_set",  sel_err3, 1);
    check("n3_no_transfer",  out_valid3, 0);
    sel3 = 2'd2;
    step();
    check("n3_sel_err_sticky", sel_err3, 1);
    check("n3_valid_sel_data", out_data3, 16'h3333);
    in_valid3 = '0;
    sel3      = 2'd0;
    step();

    // Asynchronous reset while full and stalled
    sel       = 2'd3;
    in_valid  = 4'b1000;
    set_ch(3, 16'hBEEF);
    out_ready = 1'b0;
    step();
    check("pre_rst_full", out_valid, 1);
    check("pre_rst_data", out_data, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid",   out_valid, 0);
    check("async_rst_data",    out_data, 0);
    check("async_rst_sel_err", sel_err3, 0);
    out_ready = 1'b1;
    #1;
    check("async_rst_ready", in_ready, 0);
    step();
    check("held_rst_valid", out_valid, 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 4'b1000);
    check("post_rst_empty", out_valid, 0);
    step();
    check("post_rst_xfer", out_data, 16'hBEEF);
    in_valid = '0;
    step();

`ifdef MUX_N_REG_RR_EN
    // Round-robin over four always-valid channels, from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 16'(16'h00A0 + i));
    rr_mode  = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_out_ch",   out_ch, k % 4);
      check("rr_out_data", out_data, 16'h00A0 + (k % 4));
    end
    in_valid = '0;
    rr_mode  = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
